// File: rtl/branch_resolve_unit.sv
// SPARC-style Bicc branch resolver. It holds a bank of 4-bit condition-code registers and
// evaluates one branch per cycle, or parks the branch until an in-flight CC write lands.

module branch_cc_reg (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       we,
    input  logic [3:0] wdata,
    output logic [3:0] q
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q <= 4'b0000;
        else if (we)
            q <= wdata;
    end
endmodule

module branch_resolve_unit #(
    parameter  int ADDR_W = 32,
    parameter  int NUM_CC = 2,
    localparam int SEL_W  = (NUM_CC > 1) ? $clog2(NUM_CC) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cc_we,
    input  logic [SEL_W-1:0]      cc_wsel,
    input  logic [3:0]            cc_wdata,
    input  logic                  cc_pending,
    input  logic                  br_valid,
    input  logic [3:0]            br_cond,
    input  logic                  br_annul,
    input  logic [SEL_W-1:0]      br_ccsel,
    input  logic [ADDR_W-1:0]     br_pc,
    input  logic [ADDR_W-1:0]     br_disp,
    output logic                  br_ready,
    output logic                  res_valid,
    output logic                  res_taken,
    output logic                  res_annul_slot,
    output logic [ADDR_W-1:0]     res_target,
    output logic [4*NUM_CC-1:0]   cc_out
);
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    typedef struct packed {
        logic [3:0]        cond;
        logic              annul;
        logic [SEL_W-1:0]  ccsel;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] disp;
    } br_t;

    // Flag order in each register: {V, C, N, Z}.
    function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] f);
        logic base;
        case (cond[2:0])
            3'd0:    base = 1'b0;
            3'd1:    base = f[0];
            3'd2:    base = f[0] | (f[1] ^ f[3]);
            3'd3:    base = f[1] ^ f[3];
            3'd4:    base = f[2] | f[0];
            3'd5:    base = f[2];
            3'd6:    base = f[1];
            default: base = f[3];
        endcase
        // The upper half of the encoding is the complement; 1000 becomes "always".
        return base ^ cond[3];
    endfunction

    logic [NUM_CC-1:0][3:0] cc_q;

    for (genvar i = 0; i < NUM_CC; i++) begin : g_cc
        branch_cc_reg u_cc (
            .clk     (clk),
            .reset_n (reset_n),
            .we      (cc_we && (cc_wsel == SEL_W'(i))),
            .wdata   (cc_wdata),
            .q       (cc_q[i])
        );
    end

    assign cc_out = cc_q;

    state_t            state_q, state_d;
    br_t               lat_q, lat_d;
    br_t               in_br, cur;
    logic              eval;
    logic              in_range;
    logic [3:0]        flags;
    logic              taken, annul_slot;
    logic [ADDR_W-1:0] target;

    assign in_br = '{cond: br_cond, annul: br_annul, ccsel: br_ccsel, pc: br_pc, disp: br_disp};

    always_comb begin
        cur      = (state_q == IDLE) ? in_br : lat_q;
        in_range = (32'(cur.ccsel) < NUM_CC);
        flags    = 4'b0000;
        if (in_range) begin
            if (cc_we && (cc_wsel == cur.ccsel))
                flags = cc_wdata;
            else
                flags = cc_q[cur.ccsel];
        end
        taken      = cond_taken(cur.cond, flags);
        annul_slot = cur.annul & (~taken | (cur.cond == 4'b1000));
        target     = taken ? (cur.pc + cur.disp) : (cur.pc + ADDR_W'(8));
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        eval    = 1'b0;
        case (state_q)
            IDLE: begin
                if (br_valid) begin
                    if (cc_pending) begin
                        lat_d   = in_br;
                        state_d = WAIT;
                    end else begin
                        eval = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!cc_pending) begin
                    eval    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign br_ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Result fields only move on a resolve so they stay readable between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid      <= 1'b0;
            res_taken      <= 1'b0;
            res_annul_slot <= 1'b0;
            res_target     <= '0;
        end else begin
            res_valid <= eval;
            if (eval) begin
                res_taken      <= taken;
                res_annul_slot <= annul_slot;
                res_target     <= target;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit; expected values are hand-derived.

module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cc_we;
    logic [0:0]  cc_wsel;
    logic [3:0]  cc_wdata;
    logic        cc_pending;
    logic        br_valid;
    logic [3:0]  br_cond;
    logic        br_annul;
    logic [0:0]  br_ccsel;
    logic [31:0] br_pc;
    logic [31:0] br_disp;
    logic        br_ready;
    logic        res_valid;
    logic        res_taken;
    logic        res_annul_slot;
    logic [31:0] res_target;
    logic [7:0]  cc_out;

    int nvec = 0;
    int nmis = 0;

    branch_resolve_unit #(.ADDR_W(32), .NUM_CC(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cc_we          (cc_we),
        .cc_wsel        (cc_wsel),
        .cc_wdata       (cc_wdata),
        .cc_pending     (cc_pending),
        .br_valid       (br_valid),
        .br_cond        (br_cond),
        .br_annul       (br_annul),
        .br_ccsel       (br_ccsel),
        .br_pc          (br_pc),
        .br_disp        (br_disp),
        .br_ready       (br_ready),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_annul_slot (res_annul_slot),
        .res_target     (res_target),
        .cc_out         (cc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input logic [3:0] cond, input logic a, input logic sel,
                          input logic [31:0] pc, input logic [31:0] disp);
        br_valid = 1'b1;
        br_cond  = cond;
        br_annul = a;
        br_ccsel = sel;
        br_pc    = pc;
        br_disp  = disp;
    endtask

    task automatic expect_res(input string tag, input logic t, input logic an, input logic [31:0] tgt);
        chk({tag, ".valid"}, res_valid, 1);
        chk({tag, ".taken"}, res_taken, t);
        chk({tag, ".annul"}, res_annul_slot, an);
        chk({tag, ".target"}, res_target, tgt);
    endtask

    // cond, expected taken with cc0 = {V,C,N,Z} = 0010
    logic [3:0] ctab_cond [6] = '{4'b0110, 4'b1110, 4'b0101, 4'b1101, 4'b0100, 4'b0010};
    logic       ctab_tk   [6] = '{1'b1,    1'b0,    1'b0,    1'b1,    1'b0,    1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; cc_we = 0; cc_wsel = 0; cc_wdata = 0; cc_pending = 0;
        br_valid = 0; br_cond = 0; br_annul = 0; br_ccsel = 0; br_pc = 0; br_disp = 0;
        tick; tick;
        chk("rst.valid", res_valid, 0);
        chk("rst.cc_out", cc_out, 0);
        chk("rst.target", res_target, 0);
        chk("rst.taken", res_taken, 0);
        reset_n = 1'b1;
        tick;
        chk("post_rst.ready", br_ready, 1);

        // be on cc0 after Z written
        cc_we = 1; cc_wsel = 0; cc_wdata = 4'b0001;
        tick;
        cc_we = 0;
        chk("cc0_write", cc_out, 8'h01);
        branch(4'b0001, 0, 0, 32'h100, 32'h40);
        tick;
        br_valid = 0;
        expect_res("be", 1, 0, 32'h140);
        tick;
        chk("be.pulse_end", res_valid, 0);
        chk("be.hold_target", res_target, 32'h140);

        // bne,a on cc1 with same-cycle write of V only: bypass gives Z=0
        cc_we = 1; cc_wsel = 1; cc_wdata = 4'b1000;
        branch(4'b1001, 1, 1, 32'h200, 32'h20);
        tick;
        cc_we = 0; br_valid = 0;
        expect_res("bne_bypass", 1, 0, 32'h220);
        chk("bypass.cc_out", cc_out, 8'h81);

        // back-to-back in IDLE
        branch(4'b0001, 0, 0, 32'h300, 32'h10);
        tick;
        expect_res("b2b0", 1, 0, 32'h310);
        chk("b2b0.ready", br_ready, 1);
        branch(4'b1001, 0, 0, 32'h400, 32'h10);
        tick;
        br_valid = 0;
        expect_res("b2b1", 0, 0, 32'h408);

        // bl waits three pending cycles, then resolves on bypassed N=1
        cc_pending = 1;
        branch(4'b0011, 0, 0, 32'h500, 32'h100);
        tick;
        br_valid = 1; br_cond = 4'b1000; br_pc = 32'hDEAD0000;
        chk("bl.wait1.ready", br_ready, 0);
        chk("bl.wait1.valid", res_valid, 0);
        tick;
        chk("bl.wait2.ready", br_ready, 0);
        chk("bl.wait2.valid", res_valid, 0);
        tick;
        cc_pending = 0; cc_we = 1; cc_wsel = 0; cc_wdata = 4'b0010;
        chk("bl.wait3.ready", br_ready, 0);
        chk("bl.wait3.valid", res_valid, 0);
        tick;
        cc_we = 0; br_valid = 0;
        expect_res("bl", 1, 0, 32'h600);
        chk("bl.ready_back", br_ready, 1);
        tick;
        chk("bl.pulse_end", res_valid, 0);

        // ba,a and bn,a
        branch(4'b1000, 1, 0, 32'h700, 32'h30);
        tick;
        expect_res("ba_a", 1, 1, 32'h730);
        branch(4'b0000, 1, 0, 32'h800, 32'h30);
        tick;
        expect_res("bn_a", 0, 1, 32'h808);

        // wraparound target
        branch(4'b1000, 0, 0, 32'hFFFFFFF8, 32'h10);
        tick;
        expect_res("ba_wrap", 1, 0, 32'h00000008);

        // condition table against cc0 = N only
        for (int i = 0; i < 6; i++) begin
            branch(ctab_cond[i], 0, 0, 32'h1000, 32'h80);
            tick;
            chk($sformatf("ctab%0d.valid", i), res_valid, 1);
            chk($sformatf("ctab%0d.taken", i), res_taken, ctab_tk[i]);
            chk($sformatf("ctab%0d.target", i), res_target, ctab_tk[i] ? 32'h1080 : 32'h1008);
        end
        br_valid = 0;
        tick;

        // reset while parked in WAIT drops the branch
        cc_pending = 1;
        branch(4'b0011, 0, 0, 32'h900, 32'h40);
        tick;
        br_valid = 0;
        chk("rstwait.ready", br_ready, 0);
        cc_pending = 0;
        reset_n = 0;
        #2;
        chk("rstwait.valid", res_valid, 0);
        chk("rstwait.cc_out", cc_out, 0);
        tick;
        reset_n = 1;
        tick;
        chk("rstwait.ready_after", br_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rstwait.novalid%0d", i), res_valid, 0);
            tick;
        end
        chk("rstwait.cc_out_after", cc_out, 0);
        chk("rstwait.target", res_target, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
